bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that shares the single simple-bus slave port (address, write enable, write data, byte enables, ack, read data) among N bus masters, such as the I-side and D-side bus ports of several harts. It sits between the per-core bus converters and the memory/peripheral interconnect. It grants one master per transaction and registers the winner's request onto the slave side. It returns ack to that master only, and forces completion with an error flag if the slave does not ack within a programmable timeout.

## Interface
- N_MASTERS, 2, number of requesting masters (≥2)
- TIMEOUT, 255, cycles in BUSY before forced completion; 0 disables the timeout
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_m_req  in  N_MASTERS  per-master request; held high until that master's ack
- i_m_wr_en  in  N_MASTERS  per-master write (1) / read (0)
- i_m_addr  in  32*N_MASTERS  per-master address, master k at [32k+31:32k]
- i_m_wr_data  in  32*N_MASTERS  per-master write data
- i_m_byte_en  in  4*N_MASTERS  per-master byte enables
- o_m_ack  out  N_MASTERS  one-cycle completion pulse to the granted master
- o_m_err  out  N_MASTERS  one-cycle timeout pulse, coincident with o_m_ack
- o_m_rd_data  out  32  read data broadcast to all masters; valid only with ack
- o_s_req  out  1  slave transaction active
- o_s_wr_en  out  1  registered write enable of the granted master
- o_s_addr  out  32  registered address
- o_s_wr_data  out  32  registered write data
- o_s_byte_en  out  4  registered byte enables
- i_s_ack  in  1  slave completion
- i_s_rd_data  in  32  slave read data

## Operation
- States: IDLE, BUSY.
- Grant search:
  - Performed in IDLE only.
  - Starting at index ptr, take the first k, ascending modulo N_MASTERS, with i_m_req[k]=1.
- IDLE with any request:
  - Register grant index g.
  - Register master g's wr_en, addr, wr_data and byte_en onto the o_s_* outputs.
  - Set o_s_req=1, clear the timeout counter, and go to BUSY.
  - Set ptr to (g+1) mod N_MASTERS.
- IDLE with no request: o_s_* outputs hold their values; o_s_req=0.
- BUSY:
  - The o_s_* outputs are frozen.
  - Counter increments each cycle, saturating; width $clog2(TIMEOUT+1).
- BUSY with i_s_ack=1 (combinational path):
  - o_m_ack[g]=1 and o_m_rd_data=i_s_rd_data.
  - Next state IDLE; o_s_req=0 at the next edge.
- BUSY, no ack, TIMEOUT≠0, counter==TIMEOUT-1:
  - o_m_ack[g]=1, o_m_err[g]=1, o_m_rd_data=0.
  - Next state IDLE.
- Ack and timeout in the same cycle: ack wins and o_m_err=0.
- i_s_ack while in IDLE: ignored; no master ack.
- A master dropping i_m_req while granted: the transaction still completes on the slave side, and the ack pulse is still issued.
- Masters that are not granted: o_m_ack=0 and o_m_err=0.

## Timing
- Reset values:
  - state IDLE, ptr 0, counter 0, g 0.
  - o_s_req 0, o_s_wr_en 0, o_s_addr 0, o_s_wr_data 0, o_s_byte_en 0.
  - o_m_ack 0, o_m_err 0, o_m_rd_data 0.
- Reset mid-BUSY: the transaction is abandoned, no ack is issued, and o_s_req=0 after the edge.
- A request sampled in IDLE at edge t produces o_s_req=1 with valid o_s_* from edge t+1.
- Minimum request-to-ack latency is 1 cycle, with the slave acking combinationally in the first BUSY cycle.
- There is at least one IDLE cycle between transactions. Maximum throughput is one transaction per 2 cycles.
- A master sees ack in cycle c and must drop or renew its request by c+1. A request renewed at c+1 competes under the updated ptr.
- Timeout fires in the TIMEOUT-th BUSY cycle.

## Test plan
- Single master, N=2:
  - Stimulus: master 0 reads addr 0x100, slave acks 2 cycles after o_s_req with rd_data 0xDEADBEEF.
  - Response: o_s_addr=0x100 and o_s_wr_en=0; o_m_ack=2'b01 for one cycle with o_m_rd_data=0xDEADBEEF; ptr becomes 1.
- Simultaneous requests:
  - Stimulus: both masters request continuously; master 0 writes 0x11 to 0x200, master 1 writes 0x22 to 0x300; slave acks immediately.
  - Response: grants alternate 0,1,0,1; each ack pulse is separated by one IDLE cycle.
- Byte write:
  - Stimulus: master 1 writes with byte_en 4'b0100, data 0x00AB0000, addr 0x404.
  - Response: the o_s_* outputs match exactly and remain stable throughout BUSY until ack.
- Timeout:
  - Stimulus: TIMEOUT=4, the slave never acks.
  - Response: o_m_ack[g] and o_m_err[g] pulse in the 4th BUSY cycle, o_m_rd_data=0, state returns to IDLE. The same run with i_s_ack in that 4th cycle gives o_m_err=0.
- Reset mid-BUSY:
  - Stimulus: i_rst=0 during BUSY.
  - Response: all outputs are 0 at the next edge, no ack is emitted, and after release the next grant starts from master 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bundle of the N-master request side and the single shared slave side of bus_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding masters and memory.
interface bus_arbiter_if #(
    parameter int N_MASTERS = 2
);
    logic [N_MASTERS-1:0]    i_m_req;
    logic [N_MASTERS-1:0]    i_m_wr_en;
    logic [32*N_MASTERS-1:0] i_m_addr;
    logic [32*N_MASTERS-1:0] i_m_wr_data;
    logic [4*N_MASTERS-1:0]  i_m_byte_en;
    logic [N_MASTERS-1:0]    o_m_ack;
    logic [N_MASTERS-1:0]    o_m_err;
    logic [31:0]             o_m_rd_data;
    logic                    o_s_req;
    logic                    o_s_wr_en;
    logic [31:0]             o_s_addr;
    logic [31:0]             o_s_wr_data;
    logic [3:0]              o_s_byte_en;
    logic                    i_s_ack;
    logic [31:0]             i_s_rd_data;

    modport slave (
        input  i_m_req, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        input  i_s_ack, i_s_rd_data,
        output o_m_ack, o_m_err, o_m_rd_data,
        output o_s_req, o_s_wr_en, o_s_addr, o_s_wr_data, o_s_byte_en
    );

    modport master (
        output i_m_req, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        output i_s_ack, i_s_rd_data,
        input  o_m_ack, o_m_err, o_m_rd_data,
        input  o_s_req, o_s_wr_en, o_s_addr, o_s_wr_data, o_s_byte_en
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one simple-bus slave port among N masters.
// A slave that never acks is cut off by a programmable timeout.
//   state | meaning
//   IDLE  | searching for a request from ptr; o_s_req low, o_s_* hold last values
//   BUSY  | granted transaction on slave side; o_s_* frozen, waiting for ack/timeout
module bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bus_arbiter_if.slave  bus
);
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [GW:0]   N_EXT   = (GW + 1)'(N_MASTERS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, g_q, gnt_idx, ptr_next;
    logic [CW-1:0]   cnt_q;
    logic [GW:0]     cand_sum;
    logic            req_any, ack_ev, to_ev;

    // Walk offsets from highest to lowest so the smallest offset from ptr is the one that sticks.
    always_comb begin
        req_any  = 1'b0;
        gnt_idx  = ptr_q;
        cand_sum = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            cand_sum = {1'b0, ptr_q} + (GW + 1)'(i);
            if (cand_sum >= N_EXT)
                cand_sum = cand_sum - N_EXT;
            if (bus.i_m_req[cand_sum[GW-1:0]]) begin
                req_any = 1'b1;
                gnt_idx = cand_sum[GW-1:0];
            end
        end
        ptr_next = (gnt_idx == GW'(N_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // While reset is held, ack and timeout are suppressed, so an abandoned transaction never reaches its master.
    always_comb begin
        ack_ev = (state_q == BUSY) && i_rst && bus.i_s_ack;
        to_ev  = (state_q == BUSY) && i_rst && !bus.i_s_ack
                 && (TIMEOUT != 0) && (cnt_q == TO_LAST);
    end

    always_comb begin
        state_d         = state_q;
        bus.o_m_ack     = '0;
        bus.o_m_err     = '0;
        bus.o_m_rd_data = '0;
        case (state_q)
            IDLE: if (req_any) state_d = BUSY;
            BUSY: if (ack_ev || to_ev) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ack_ev || to_ev)
            bus.o_m_ack[g_q] = 1'b1;
        if (to_ev)
            bus.o_m_err[g_q] = 1'b1;
        if (ack_ev)
            bus.o_m_rd_data = bus.i_s_rd_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            g_q             <= '0;
            cnt_q           <= '0;
            bus.o_s_wr_en   <= 1'b0;
            bus.o_s_addr    <= '0;
            bus.o_s_wr_data <= '0;
            bus.o_s_byte_en <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (req_any) begin
                    g_q             <= gnt_idx;
                    ptr_q           <= ptr_next;
                    cnt_q           <= '0;
                    bus.o_s_wr_en   <= bus.i_m_wr_en[gnt_idx];
                    bus.o_s_addr    <= bus.i_m_addr[32*gnt_idx +: 32];
                    bus.o_s_wr_data <= bus.i_m_wr_data[32*gnt_idx +: 32];
                    bus.o_s_byte_en <= bus.i_m_byte_en[4*gnt_idx +: 4];
                end
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.o_s_req = (state_q == BUSY);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_MASTERS=2, TIMEOUT=4).
// Inputs change and outputs are sampled just after the falling edge.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    bus_arbiter_if #(.N_MASTERS(2)) bus ();

    bus_arbiter #(.N_MASTERS(2), .TIMEOUT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_m_req = '0; bus.i_m_wr_en = '0; bus.i_m_addr = '0;
        bus.i_m_wr_data = '0; bus.i_m_byte_en = '0;
        bus.i_s_ack = 1'b0; bus.i_s_rd_data = '0;
        step(); step();
        n_checks++;
        if ({bus.o_s_req, bus.o_s_wr_en, bus.o_s_addr, bus.o_s_wr_data, bus.o_s_byte_en} !== '0)
            $display("FAIL reset_slave_side: got req=%b we=%b addr=%h wd=%h be=%h, expected all 0",
                     bus.o_s_req, bus.o_s_wr_en, bus.o_s_addr, bus.o_s_wr_data, bus.o_s_byte_en);
        else n_pass++;
        n_checks++;
        if ({bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data} !== '0)
            $display("FAIL reset_master_side: got ack=%b err=%b rd=%h, expected 0",
                     bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data);
        else n_pass++;
        rst = 1'b1;
        bus.i_s_ack = 1'b1; bus.i_s_rd_data = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if (bus.o_m_ack !== 2'b00 || bus.o_m_rd_data !== 32'h0)
            $display("FAIL idle_ack_ignored: got ack=%b rd=%h, expected 00/0", bus.o_m_ack, bus.o_m_rd_data);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b0;
        n_checks++;
        if (bus.o_s_req !== 1'b0)
            $display("FAIL idle_ack_no_req: got o_s_req=%b, expected 0", bus.o_s_req);
        else n_pass++;
    endtask

    task automatic test_single();
        bus.i_m_req = 2'b01; bus.i_m_wr_en = 2'b00;
        bus.i_m_addr = {32'h0000_0300, 32'h0000_0100};
        step();
        n_checks++;
        if (bus.o_s_req !== 1'b1 || bus.o_s_addr !== 32'h100 || bus.o_s_wr_en !== 1'b0)
            $display("FAIL single_issue: got req=%b addr=%h we=%b, expected 1/00000100/0",
                     bus.o_s_req, bus.o_s_addr, bus.o_s_wr_en);
        else n_pass++;
        step();
        n_checks++;
        if (bus.o_m_ack !== 2'b00)
            $display("FAIL single_wait: got ack=%b, expected 00", bus.o_m_ack);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b1; bus.i_s_rd_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (bus.o_m_ack !== 2'b01 || bus.o_m_err !== 2'b00 || bus.o_m_rd_data !== 32'hDEAD_BEEF)
            $display("FAIL single_ack: got ack=%b err=%b rd=%h, expected 01/00/deadbeef",
                     bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b0; bus.i_m_req = 2'b00;
        #1;
        n_checks++;
        if (bus.o_s_req !== 1'b0 || bus.o_m_ack !== 2'b00)
            $display("FAIL single_done: got req=%b ack=%b, expected 0/00", bus.o_s_req, bus.o_m_ack);
        else n_pass++;
        // ptr is now 1, so master 1 must win a simultaneous request.
        bus.i_m_req = 2'b11;
        step();
        n_checks++;
        if (bus.o_s_addr !== 32'h300)
            $display("FAIL ptr_after_single: got addr=%h, expected 00000300", bus.o_s_addr);
        else n_pass++;
        bus.i_s_ack = 1'b1;
        #1;
        n_checks++;
        if (bus.o_m_ack !== 2'b10)
            $display("FAIL ptr_after_single_ack: got ack=%b, expected 10", bus.o_m_ack);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b0; bus.i_m_req = 2'b00;
    endtask

    task automatic test_simultaneous();
        logic [1:0]  exp_ack;
        logic [31:0] exp_addr, exp_data;
        bus.i_m_req = 2'b11; bus.i_m_wr_en = 2'b11;
        bus.i_m_addr = {32'h0000_0300, 32'h0000_0200};
        bus.i_m_wr_data = {32'h0000_0022, 32'h0000_0011};
        bus.i_m_byte_en = 8'hFF;
        for (int n = 0; n < 4; n++) begin
            exp_ack  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (n % 2 == 0) ? 32'h200 : 32'h300;
            exp_data = (n % 2 == 0) ? 32'h11 : 32'h22;
            step();
            n_checks++;
            if (bus.o_s_req !== 1'b1 || bus.o_s_addr !== exp_addr || bus.o_s_wr_data !== exp_data
                || bus.o_s_wr_en !== 1'b1)
                $display("FAIL rr_issue_%0d: got req=%b addr=%h wd=%h we=%b, expected 1/%h/%h/1",
                         n, bus.o_s_req, bus.o_s_addr, bus.o_s_wr_data, bus.o_s_wr_en, exp_addr, exp_data);
            else n_pass++;
            bus.i_s_ack = 1'b1;
            #1;
            n_checks++;
            if (bus.o_m_ack !== exp_ack || bus.o_m_err !== 2'b00)
                $display("FAIL rr_ack_%0d: got ack=%b err=%b, expected %b/00", n, bus.o_m_ack, bus.o_m_err, exp_ack);
            else n_pass++;
            step();
            bus.i_s_ack = 1'b0;
            if (n == 3) bus.i_m_req = 2'b00;
            #1;
            n_checks++;
            if (bus.o_s_req !== 1'b0 || bus.o_m_ack !== 2'b00)
                $display("FAIL rr_gap_%0d: got req=%b ack=%b, expected 0/00", n, bus.o_s_req, bus.o_m_ack);
            else n_pass++;
        end
    endtask

    task automatic test_byte_write();
        logic [68:0] exp_s;
        exp_s = {1'b1, 4'b0100, 32'h0000_0404, 32'h00AB_0000};
        bus.i_m_req = 2'b10; bus.i_m_wr_en = 2'b10;
        bus.i_m_addr = {32'h0000_0404, 32'h0000_0999};
        bus.i_m_wr_data = {32'h00AB_0000, 32'h5555_5555};
        bus.i_m_byte_en = {4'b0100, 4'b1111};
        for (int c = 1; c <= 3; c++) begin
            step();
            // Master 1 scribbles on its inputs mid-transaction; the slave side must not follow.
            bus.i_m_addr[63:32] = 32'hFFFF_0000 + c;
            bus.i_m_wr_data[63:32] = 32'h1234_0000 + c;
            bus.i_m_byte_en[7:4] = 4'b1011;
            if (c == 3) bus.i_s_ack = 1'b1;
            #1;
            n_checks++;
            if ({bus.o_s_wr_en, bus.o_s_byte_en, bus.o_s_addr, bus.o_s_wr_data} !== exp_s || bus.o_s_req !== 1'b1)
                $display("FAIL byte_stable_%0d: got we=%b be=%b addr=%h wd=%h req=%b, expected 1/0100/00000404/00ab0000/1",
                         c, bus.o_s_wr_en, bus.o_s_byte_en, bus.o_s_addr, bus.o_s_wr_data, bus.o_s_req);
            else n_pass++;
        end
        n_checks++;
        if (bus.o_m_ack !== 2'b10)
            $display("FAIL byte_ack: got ack=%b, expected 10", bus.o_m_ack);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b0; bus.i_m_req = 2'b00;
    endtask

    task automatic test_timeout();
        bus.i_m_req = 2'b01; bus.i_m_wr_en = 2'b00;
        bus.i_m_addr = {32'h0000_0600, 32'h0000_0500};
        bus.i_s_rd_data = 32'h1234_5678;
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++;
            if (bus.o_m_ack !== 2'b00 || bus.o_m_err !== 2'b00 || bus.o_s_req !== 1'b1)
                $display("FAIL timeout_wait_%0d: got ack=%b err=%b req=%b, expected 00/00/1",
                         c, bus.o_m_ack, bus.o_m_err, bus.o_s_req);
            else n_pass++;
        end
        step();
        n_checks++;
        if (bus.o_m_ack !== 2'b01 || bus.o_m_err !== 2'b01 || bus.o_m_rd_data !== 32'h0)
            $display("FAIL timeout_fire: got ack=%b err=%b rd=%h, expected 01/01/0",
                     bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data);
        else n_pass++;
        step();
        bus.i_m_req = 2'b00;
        #1;
        n_checks++;
        if (bus.o_s_req !== 1'b0 || bus.o_m_ack !== 2'b00 || bus.o_m_err !== 2'b00)
            $display("FAIL timeout_idle: got req=%b ack=%b err=%b, expected 0/00/00",
                     bus.o_s_req, bus.o_m_ack, bus.o_m_err);
        else n_pass++;
        // Same run, but the slave acks in the cycle the timeout would fire.
        bus.i_m_req = 2'b01;
        step(); step(); step(); step();
        bus.i_s_ack = 1'b1;
        #1;
        n_checks++;
        if (bus.o_m_ack !== 2'b01 || bus.o_m_err !== 2'b00 || bus.o_m_rd_data !== 32'h1234_5678)
            $display("FAIL ack_beats_timeout: got ack=%b err=%b rd=%h, expected 01/00/12345678",
                     bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b0; bus.i_m_req = 2'b00;
    endtask

    task automatic test_reset_mid_busy();
        // The previous grant was master 0, so ptr=1 and master 1 wins first.
        bus.i_m_req = 2'b11; bus.i_m_wr_en = 2'b00;
        bus.i_m_addr = {32'h0000_0700, 32'h0000_0800};
        step();
        n_checks++;
        if (bus.o_s_addr !== 32'h700 || bus.o_s_req !== 1'b1)
            $display("FAIL rst_pre_grant: got addr=%h req=%b, expected 00000700/1", bus.o_s_addr, bus.o_s_req);
        else n_pass++;
        rst = 1'b0; bus.i_s_ack = 1'b1;
        #1;
        n_checks++;
        if (bus.o_m_ack !== 2'b00 || bus.o_m_err !== 2'b00)
            $display("FAIL rst_no_ack: got ack=%b err=%b, expected 00/00", bus.o_m_ack, bus.o_m_err);
        else n_pass++;
        step();
        n_checks++;
        if ({bus.o_s_req, bus.o_s_wr_en, bus.o_s_addr, bus.o_s_wr_data, bus.o_s_byte_en,
             bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data} !== '0)
            $display("FAIL rst_all_zero: got req=%b addr=%h ack=%b err=%b rd=%h, expected all 0",
                     bus.o_s_req, bus.o_s_addr, bus.o_m_ack, bus.o_m_err, bus.o_m_rd_data);
        else n_pass++;
        rst = 1'b1; bus.i_s_ack = 1'b0;
        step();
        n_checks++;
        if (bus.o_s_addr !== 32'h800 || bus.o_s_req !== 1'b1)
            $display("FAIL rst_grant_m0: got addr=%h req=%b, expected 00000800/1", bus.o_s_addr, bus.o_s_req);
        else n_pass++;
        bus.i_s_ack = 1'b1;
        #1;
        n_checks++;
        if (bus.o_m_ack !== 2'b01)
            $display("FAIL rst_grant_m0_ack: got ack=%b, expected 01", bus.o_m_ack);
        else n_pass++;
        step();
        bus.i_s_ack = 1'b0; bus.i_m_req = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_byte_write();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
